uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the one UART transmit line; legal range 2..8.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit period; legal range 2..65535.
REQ-003 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-004 Parameter STOP_BITS, default 2: stop bits per frame; legal values 1 or 2.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-009 req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-010 req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-011 tx  output  1  registered UART serial line; idles high.
REQ-012 busy  output  1  high from the cycle after a grant through the last stop-bit cycle.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the requester owning the current frame; holds its last value when idle.
REQ-014 frame_done  output  1  one-cycle pulse on the final clk cycle of the last stop bit.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PAR and STOP.
REQ-016 In IDLE, the block SHALL combinationally assert req_ready for exactly one requester: the first with req_valid high, searching from rr_ptr upward modulo NUM_REQ; all other req_ready bits stay low.
REQ-017 req_ready SHALL be low in every state other than IDLE.
REQ-018 On a transfer, the block SHALL latch the byte and grant_id, set rr_ptr to (winner+1) mod NUM_REQ, and enter START on the next cycle.
REQ-019 With no req_valid high in IDLE, the block SHALL remain in IDLE, and rr_ptr SHALL not change.
REQ-020 Requesters SHALL hold req_valid and req_data stable until their transfer; the block does not buffer any withdrawn request.
REQ-021 Each of START, each DATA bit, PAR and each STOP bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads at every bit boundary.
REQ-022 tx values: 0 in START; data bits LSB first in DATA; XOR of the 8 data bits in PAR; 1 in STOP and IDLE.
REQ-023 Transitions: DATA to PAR after bit 7 if PARITY_EN=1, otherwise DATA to STOP; PAR to STOP; STOP to IDLE after STOP_BITS bit periods.
REQ-024 Latency: a grant in cycle 0 SHALL produce the tx falling edge in cycle 1.
REQ-025 Frame length SHALL be (9+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, and frame_done SHALL pulse in the last of those cycles.
REQ-026 Back-to-back frames SHALL have exactly one IDLE cycle between them, with tx high in that cycle.
REQ-027 The bit-period counter SHALL be 16 bits wide, and the data-bit index SHALL wrap from 7 to 0 without aliasing into the next frame.

Reset
REQ-028 While rst_n is low, outputs SHALL be: tx=1, busy=0, req_ready=0, frame_done=0, grant_id=0.
REQ-029 While rst_n is low, internal state SHALL be: state IDLE, rr_ptr=0, counters 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately without a frame_done pulse; tx returns high asynchronously.
REQ-031 After rst_n deasserts, the first grant SHALL be eligible on the first rising clk edge.

Verification
All scenarios use NUM_REQ=4, CLKS_PER_BIT=4, PARITY_EN=1, STOP_BITS=2 unless stated otherwise.
REQ-032 req_valid=0001 with data 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1,1, each value held 4 cycles; frame_done at cycle 48 after the grant; grant_id=0.
REQ-033 req_valid=1111 held from reset, with bytes 0x11,0x22,0x33,0x44 -> grants in order 0,1,2,3, one IDLE cycle between frames, and the four frames carry the matching bytes.
REQ-034 req_valid=0101 held continuously -> grant sequence 0,2,0,2, and requesters 1 and 3 never receive req_ready.
REQ-035 rst_n pulsed low during DATA bit 3 of a frame from requester 2 -> tx=1 and busy=0 in the same cycle, no frame_done; after release with req_valid=0100, the next grant goes to requester 2 and a full frame follows.
REQ-036 PARITY_EN=0, STOP_BITS=1, data 0xFF -> tx sequence 0, eight 1s, 1; frame length 40 cycles.
REQ-037 Every frame -> exactly one frame_done pulse, and at most one req_ready bit high in any cycle (bench assertions).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8-bit UART transmitter (start, data LSB first, optional even parity, stop bits).
// Grant in IDLE takes effect at the next edge and tx falls one cycle later; req_ready stays low while a frame is on the line.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int STOP_BITS    = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       frame_done
);

   localparam int             IDW      = $clog2(NUM_REQ);
   localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NUM_REQ);
   localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ-1);
   localparam logic [15:0]    CNT_LAST = 16'(CLKS_PER_BIT-1);
   localparam logic [15:0]    CNT_PRE  = 16'(CLKS_PER_BIT-2);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t          state;
   logic [15:0]     bit_cnt;
   logic [2:0]      bit_idx;
   logic            stop_idx;
   logic [7:0]      shreg;
   logic            par_bit;
   logic [IDW-1:0]  rr_ptr;

   logic [2*NUM_REQ-1:0] dbl_valid;
   logic [NUM_REQ-1:0]   rot_valid;
   logic                 found;
   logic [IDW:0]         raw_sum;
   logic [IDW-1:0]       winner;
   logic [IDW-1:0]       next_ptr;
   logic [7:0]           win_data;
   logic                 bit_end;
   logic                 last_stop;

   // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit is the winner.
   assign dbl_valid = {req_valid, req_valid};
   assign rot_valid = NUM_REQ'(dbl_valid >> rr_ptr);

   always_comb begin
      found   = 1'b0;
      raw_sum = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            found   = 1'b1;
            raw_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
         end
      end
   end

   assign winner   = (raw_sum >= NREQ_W) ? IDW'(raw_sum - NREQ_W) : raw_sum[IDW-1:0];
   assign next_ptr = (winner == LAST_ID) ? '0 : winner + IDW'(1);

   always_comb begin
      win_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (winner == IDW'(k)) win_data = req_data[8*k +: 8];
      end
   end

   assign req_ready = (rst_n && state == IDLE && found) ? (NUM_REQ'(1) << winner) : '0;
   assign bit_end   = (bit_cnt == CNT_LAST);
   assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         rr_ptr     <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         grant_id   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (state != IDLE) bit_cnt <= bit_end ? '0 : bit_cnt + 16'd1;
         case (state)
            IDLE: begin
               if (found) begin
                  shreg    <= win_data;
                  par_bit  <= ^win_data;
                  grant_id <= winner;
                  rr_ptr   <= next_ptr;
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  stop_idx <= 1'b0;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx    <= shreg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     if (PARITY_EN != 0) begin
                        tx    <= par_bit;
                        state <= PAR;
                     end else begin
                        tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end
            end
            PAR: begin
               if (bit_end) begin
                  tx    <= 1'b1;
                  state <= STOP;
               end
            end
            STOP: begin
               // Raised one cycle early so the registered pulse lands on the frame's final cycle.
               if (last_stop && bit_cnt == CNT_PRE) frame_done <= 1'b1;
               if (bit_end) begin
                  if (last_stop) begin
                     stop_idx <= 1'b0;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
